// File: rtl/phy_write_sequencer.sv
// PHY write-mode sequencer: loads one burst into the PHY FIFO, waits out tCWL, then opens the drive window.
// Optional build macro PHY_WRITE_ACK_CHECK_EN adds a sticky ack_err for missing or stray phy_ack.
module phy_write_sequencer #(
  parameter int MEM_DATAWIDTH = 64,
  parameter int BURST_LENGTH  = 8,
  parameter int CWL_CYCLES    = 12,
  parameter int MIN_GAP       = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  cmd_valid,
  output logic                                  cmd_ready,
  input  logic                                  wb_valid,
  input  logic [MEM_DATAWIDTH-1:0]              wb_data,
  input  logic [MEM_DATAWIDTH/BURST_LENGTH-1:0] wb_strb,
  output logic                                  wb_ready,
  output logic                                  phy_inflag,
  output logic [MEM_DATAWIDTH-1:0]              phy_indata,
  output logic [MEM_DATAWIDTH/BURST_LENGTH-1:0] phy_instrb,
  output logic                                  phy_outflag,
  input  logic                                  phy_ack,
  output logic                                  wr_done,
  output logic                                  underrun_err,
  output logic                                  busy
`ifdef PHY_WRITE_ACK_CHECK_EN
  ,
  output logic                                  ack_err
`endif
);

  localparam int BW = $clog2(BURST_LENGTH) + 1;
  localparam int CW = $clog2(CWL_CYCLES + 1);
  localparam int GW = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_DRIVE, S_GAP} state_t;

  state_t        state, state_d;
  logic [BW-1:0] beat_cnt;
  logic [CW-1:0] cwl_cnt;
  logic [GW-1:0] gap_cnt;
  logic          beat_xfer, load_last, drive_last, gap_last, cwl_expiring, inflag_d;

  assign cmd_ready   = (state == S_IDLE);
  assign busy        = (state != S_IDLE);
  assign wb_ready    = (state == S_LOAD);
  assign phy_outflag = (state == S_DRIVE);
  assign beat_xfer   = wb_ready & wb_valid;
  assign load_last   = beat_xfer && (beat_cnt == BW'(BURST_LENGTH - 1));
  assign drive_last  = (state == S_DRIVE) && (beat_cnt == BW'(BURST_LENGTH / 2 - 1));
  assign gap_last    = (state == S_GAP) && (gap_cnt == GW'(MIN_GAP - 1));
  assign wr_done     = drive_last;
  // Counter hits 0 at this edge, so the next cycle is exactly CWL_CYCLES after accept.
  assign cwl_expiring = (cwl_cnt <= CW'(1));

  always_comb begin
    state_d  = state;
    inflag_d = 1'b0;
    case (state)
      S_IDLE:  if (cmd_valid) state_d = S_LOAD;
      S_LOAD: begin
        inflag_d = beat_xfer;
        if (load_last) state_d = cwl_expiring ? S_DRIVE : S_WAIT;
      end
      S_WAIT: begin
        inflag_d = 1'b1;
        if (cwl_expiring) state_d = S_DRIVE;
      end
      S_DRIVE: begin
        inflag_d = !drive_last;
        if (drive_last) state_d = (MIN_GAP > 0) ? S_GAP : S_IDLE;
      end
      S_GAP:   if (gap_last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      beat_cnt     <= '0;
      cwl_cnt      <= '0;
      gap_cnt      <= '0;
      phy_inflag   <= 1'b0;
      phy_indata   <= '0;
      phy_instrb   <= '0;
      underrun_err <= 1'b0;
    end else begin
      state      <= state_d;
      phy_inflag <= inflag_d;
      if (beat_xfer) begin
        phy_indata <= wb_data;
        phy_instrb <= wb_strb;
      end
      // beat_cnt doubles as the drive-window counter; a stall restarts the load from beat 0
      case (state)
        S_LOAD:  beat_cnt <= (beat_xfer && !load_last) ? beat_cnt + BW'(1) : '0;
        S_DRIVE: beat_cnt <= drive_last ? '0 : beat_cnt + BW'(1);
        default: beat_cnt <= '0;
      endcase
      if (state == S_IDLE) begin
        if (cmd_valid) cwl_cnt <= CW'(CWL_CYCLES - 1);
      end else if (cwl_cnt != '0) begin
        cwl_cnt <= cwl_cnt - CW'(1);
      end
      gap_cnt <= (state == S_GAP) ? gap_cnt + GW'(1) : '0;
      if (state == S_LOAD && cwl_cnt == '0) underrun_err <= 1'b1;
    end
  end

`ifdef PHY_WRITE_ACK_CHECK_EN
  logic ack_seen;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_seen <= 1'b0;
      ack_err  <= 1'b0;
    end else begin
      if (state == S_DRIVE && !drive_last) ack_seen <= ack_seen | phy_ack;
      else                                 ack_seen <= 1'b0;
      if ((drive_last && !(ack_seen | phy_ack)) || (state == S_IDLE && phy_ack))
        ack_err <= 1'b1;
    end
  end
`else
  logic unused_phy_ack;
  assign unused_phy_ack = phy_ack;
`endif

endmodule
